// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - frames UART RX bytes into ALU operations and returns the result as two TX bytes
// Optional ALU_TIMEOUT_EN: an unanswered ALU request yields 0xEEEE and a CMD_ERR pulse.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int FUN_WIDTH   = 4,
  parameter int RES_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  input  logic [RES_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] CMD_NEW   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT_RES, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI
  } state_t;

  state_t                  state, state_nxt;
  logic [RES_WIDTH-1:0]    result;
  logic [DATA_WIDTH-1:0]   tx_hold;
  logic                    busy_seen;
  logic                    cmd_err_nxt;
  logic                    timeout;

  if (RES_WIDTH != 2 * DATA_WIDTH || TIMEOUT_CYC < 1) begin : g_param_check
    $error("alu_cmd_sequencer: RES_WIDTH must be 2*DATA_WIDTH and TIMEOUT_CYC >= 1");
  end

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC < 16) ? 4 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [RES_WIDTH-1:0] TIMEOUT_RES = RES_WIDTH'({(RES_WIDTH/4){4'hE}});
  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside WAIT_RES, so every entry starts a fresh count.
  always_ff @(posedge CLK) begin
    if (RST || state != WAIT_RES) wait_cnt <= '0;
    else if (!ALU_OUT_VLD)        wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT_RES) && !ALU_OUT_VLD && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (RX_D_VLD) begin
        if (RX_P_DATA == CMD_NEW)        state_nxt = GET_A;
        else if (RX_P_DATA == CMD_REUSE) state_nxt = GET_FUN;
      end
      GET_A:    if (RX_D_VLD) state_nxt = GET_B;
      GET_B:    if (RX_D_VLD) state_nxt = GET_FUN;
      GET_FUN:  if (RX_D_VLD) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_RES;
      WAIT_RES: if (ALU_OUT_VLD || timeout) state_nxt = SEND_LO;
      SEND_LO:  if (!TX_BUSY) state_nxt = WAIT_LO;
      WAIT_LO:  if (busy_seen && !TX_BUSY) state_nxt = SEND_HI;
      SEND_HI:  if (!TX_BUSY) state_nxt = WAIT_HI;
      WAIT_HI:  if (busy_seen && !TX_BUSY) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // TX_P_DATA only moves in the cycle a request is made; otherwise it shows the last byte sent.
  always_comb begin
    ALU_EN      = (state == ISSUE);
    TX_D_VLD    = 1'b0;
    TX_P_DATA   = tx_hold;
    cmd_err_nxt = timeout;
    case (state)
      IDLE: if (RX_D_VLD && RX_P_DATA != CMD_NEW && RX_P_DATA != CMD_REUSE) cmd_err_nxt = 1'b1;
      SEND_LO: if (!TX_BUSY) begin
        TX_D_VLD  = 1'b1;
        TX_P_DATA = result[DATA_WIDTH-1:0];
      end
      SEND_HI: if (!TX_BUSY) begin
        TX_D_VLD  = 1'b1;
        TX_P_DATA = result[RES_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      result    <= '0;
      tx_hold   <= '0;
      busy_seen <= 1'b0;
      CMD_ERR   <= 1'b0;
    end else begin
      CMD_ERR <= cmd_err_nxt;
      if (TX_D_VLD) tx_hold <= TX_P_DATA;
      if (RX_D_VLD) begin
        case (state)
          GET_A:   ALU_A   <= RX_P_DATA;
          GET_B:   ALU_B   <= RX_P_DATA;
          GET_FUN: ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (state == WAIT_RES) begin
        if (ALU_OUT_VLD) result <= ALU_OUT;
`ifdef ALU_TIMEOUT_EN
        else if (timeout) result <= TIMEOUT_RES;
`endif
      end
      // Tracks the busy rise of the transmitter; cleared in SEND_HI between the two waits.
      busy_seen <= (state == WAIT_LO || state == WAIT_HI) && (busy_seen || TX_BUSY);
    end
  end

endmodule
